grasspopper_decoder: RTL

Iterative GOST R 34.12-2015 (Kuznyechik) block decryptor: the inverse of the `grasspopper` encryption core. It takes one 128-bit ciphertext block and returns the plaintext after nine inverse rounds, one round at a time, with a byte-serial inverse linear layer. Round keys come from an external key-schedule source through an index/data lookup, so the encoder and decoder share one key store.

---
 rtl/grasspopper_pi_inv.sv | 32 +++
 rtl/grasspopper_decoder.sv | 115 +++++++++++
 2 files changed

// File: rtl/grasspopper_pi_inv.sv
// Kuznyechik inverse S-box pi^-1 as a 256-entry constant lookup.
// The inverse table is built at elaboration from the forward pi table.
module grasspopper_pi_inv (
  input  logic [7:0] x,
  output logic [7:0] y
);

  // Forward pi, entry 0 in the most significant byte.
  localparam logic [2047:0] PI = {
    128'hfceedd11cf6e3116fbc4fada23c5044d, 128'he977f0db932e99ba1736f1bb14cd5fc1,
    128'hf918655ae25cef21811c3c428b018e4f, 128'h058402aee36a8fa0060bed987fd4d31f,
    128'heb342c51eac848abf22a68a2fd3acecc, 128'hb5700e56080c7612bf7213479cb75d87,
    128'h15a19629107b9ac7f391786f9d9eb2b1, 128'h3275193dff358a7e6d54c680c3bd0d57,
    128'hdff524a93ea843c9d779d6f67c22b903, 128'he00fecde7a94b0bcdce828504e330a4a,
    128'ha79760731e0062441ab83882649f2641, 128'had454692275e552f8ca3a57d69d5953b,
    128'h0758b34086ac1df730376be488d9e789, 128'he11b83494c3ff8fe8d53aa90cad88561,
    128'h207167a42d2b095bcb9b25d0bee56c52, 128'h59a674d2e6f4b4c0d166afc2394b63b6
  };

  function automatic logic [2047:0] build_inv();
    logic [2047:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[{PI[2047-8*i -: 8], 3'b000} +: 8] = 8'(i);
    return t;
  endfunction

  // pi^-1, entry v at bits [8v+7:8v].
  localparam logic [2047:0] PI_INV = build_inv();

  assign y = PI_INV[{x, 3'b000} +: 8];

endmodule

// File: rtl/grasspopper_decoder.sv
// Iterative Kuznyechik block decryptor: nine inverse rounds, byte-serial L^-1.
// state | meaning
// IDLE  | waiting for a block, requests K10 for the initial whitening
// LINV  | one R^-1 step per cycle, 16 steps per round
// SUB   | S^-1 on all bytes and round-key add; last round publishes data_o
module grasspopper_decoder (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_i,
  input  logic         valid_i,
  output logic [3:0]   rk_idx_o,
  input  logic [127:0] rk_i,
  output logic [127:0] data_o,
  output logic         valid_o,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LINV, SUB} state_t;

  // l coefficients, b15 in the top byte.
  localparam logic [127:0] L_COEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  state_t       fsm;
  logic [127:0] blk;
  logic [3:0]   round;
  logic [3:0]   cnt;
  logic [127:0] rot;
  logic [7:0]   l_val;
  logic [127:0] r_inv;
  logic [127:0] sub;
  logic [127:0] sub_key;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] k);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'hc3 : 8'h00);
    end
    return p;
  endfunction

  // R^-1 feeds l with (a14..a0, a15), i.e. the block rotated left one byte.
  always_comb begin
    rot   = {blk[119:0], blk[127:120]};
    l_val = '0;
    for (int j = 0; j < 16; j++) l_val = l_val ^ gf_mul(rot[8*j +: 8], L_COEF[8*j +: 8]);
  end

  assign r_inv = {blk[119:0], l_val};

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    grasspopper_pi_inv u_pi_inv (
      .x (blk[8*g +: 8]),
      .y (sub[8*g +: 8])
    );
  end

  assign sub_key = sub ^ rk_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm      <= IDLE;
      blk      <= '0;
      round    <= 4'd9;
      cnt      <= '0;
      rk_idx_o <= 4'd10;
      data_o   <= '0;
      valid_o  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (fsm)
        IDLE: begin
          if (valid_i && !busy) begin
            blk      <= data_i ^ rk_i;
            round    <= 4'd9;
            cnt      <= '0;
            rk_idx_o <= 4'd9;
            busy     <= 1'b1;
            fsm      <= LINV;
          end
        end
        LINV: begin
          blk <= r_inv;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) fsm <= SUB;
        end
        SUB: begin
          blk <= sub_key;
          if (round == 4'd1) begin
            data_o   <= sub_key;
            valid_o  <= 1'b1;
            busy     <= 1'b0;
            round    <= 4'd9;
            rk_idx_o <= 4'd10;
            fsm      <= IDLE;
          end else begin
            round    <= round - 4'd1;
            rk_idx_o <= round - 4'd1;
            cnt      <= '0;
            fsm      <= LINV;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
